keyfob_decoder: RTL and testbench
=================================

# keyfob_decoder

Serial receiver for the remote keyfob link that arms and disarms the car alarm. Samples the single-wire RF demodulator output, reassembles each frame (start, 16-bit device ID, 2-bit command, even parity, stop), checks ID, parity and framing, and delivers a one-cycle command strobe to the alarm FSM. Runs on the 50 MHz system clock, ahead of the 1 Hz clock divider, and is the receiving end of the keyfob transmitter's frame format.

## Interface
- BIT_TICKS, 5000: clock cycles per bit (10 kbit/s at 50 MHz); even, at least 4.
- DEVICE_ID, 16'hA5C3: ID this car accepts.
- clk  input  1  system clock, 50 MHz, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rf_in  input  1  asynchronous serial line; idle high.
- cmd  output  2  last accepted command: 0 arm, 1 disarm, 2 panic, 3 trunk.
- cmd_valid  output  1  one-cycle strobe; cmd is valid in that cycle.
- frame_err  output  1  one-cycle strobe on parity or stop-bit failure.
- id_miss  output  1  one-cycle strobe on a well-formed frame with a foreign ID.
- busy  output  1  high while a frame is being received (any state except IDLE).

## Operation
- rf_in passes through a 2-flop synchronizer (rf_s). A falling edge is rf_s == 0 with the previous rf_s == 1.
- Frame on the wire, each bit BIT_TICKS long, LSB first: start (0), ID[15:0], CMD[1:0], P, stop (1). P makes the count of ones in ID, CMD and P even.
- States:
  - IDLE: on a falling edge, load the tick counter and go to START.
  - START: at mid-bit, if rf_s == 1 the start is false; go to IDLE with no strobe. Otherwise go to DATA with bit index 0.
  - DATA: sample rf_s into an 18-bit shift register each bit period; after index 17, go to PARITY.
  - PARITY: sample P and go to STOP.
  - STOP: sample the stop bit, then evaluate the frame:
    - stop == 0 or parity fails: frame_err, then go to WAIT_IDLE if stop == 0, else IDLE.
    - otherwise, ID != DEVICE_ID: id_miss, then IDLE.
    - otherwise: load cmd, pulse cmd_valid, then IDLE.
  - WAIT_IDLE: stay until rf_s == 1, then go to IDLE. This blocks break conditions from retriggering.
- frame_err takes priority over id_miss. At most one strobe fires per frame.
- cmd holds its value between accepted frames. It never changes on an error or an ID miss.
- Falling edges outside IDLE are ignored; the receiver never resynchronizes mid-frame.

## Timing
- Reset values: cmd = 0, cmd_valid = 0, frame_err = 0, id_miss = 0, busy = 0; state IDLE; synchronizer flops at 1.
- Let E be the cycle in which the falling edge is detected on rf_s (2 cycles after rf_in falls).
- Start sample at E + BIT_TICKS/2. Data bit k (k = 0..17) at E + BIT_TICKS/2 + (k+1)*BIT_TICKS. Parity at E + BIT_TICKS/2 + 19*BIT_TICKS. Stop at E + BIT_TICKS/2 + 20*BIT_TICKS.
- Strobes are registered: asserted in the cycle after the stop sample, for exactly 1 cycle. busy falls in that same cycle.
- A new falling edge is accepted 1 cycle after the return to IDLE. Back-to-back frames with a 1-bit stop work.
- The tick counter is ceil(log2(BIT_TICKS)) bits wide and reloads on each sample.
- Asserting rst mid-frame aborts immediately. No strobe is produced and all outputs take their reset values asynchronously.

## Test plan
Bench uses BIT_TICKS = 8.
- Valid frame, ID A5C3, CMD 1, correct P, stop 1 -> cmd_valid high for 1 cycle at E+165, cmd = 1; frame_err and id_miss stay 0.
- Same frame with P inverted -> frame_err for 1 cycle at E+165; cmd keeps its previous value; cmd_valid stays 0.
- Frame with ID 1234, otherwise valid -> id_miss for 1 cycle; cmd unchanged.
- Stop bit 0, line held low for 50 cycles, then valid frame CMD 2 -> frame_err once, no retrigger while low, then cmd_valid with cmd = 2.
- 3-cycle low glitch on rf_in -> false start, back to IDLE; no strobes; busy high only for the glitch window (until E+4).
- rst pulsed low at data bit 10 of a valid frame -> all outputs 0 at once; no strobe; the next full valid frame CMD 3 decodes with cmd = 3.

Source files
------------

// File: rtl/keyfob_decoder.sv
// Keyfob RF frame receiver: start, 16-bit ID, 2-bit command, even parity, stop.
// Validates framing, parity and device ID, then emits a one-cycle result strobe.
module keyfob_decoder #(
    parameter int unsigned BIT_TICKS = 5000,
    parameter logic [15:0] DEVICE_ID = 16'hA5C3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rf_in,
    output logic [1:0] cmd,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       id_miss,
    output logic       busy
);

    localparam int unsigned CW = $clog2(BIT_TICKS);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_TICKS / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q, prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      idx_q, idx_d;
    logic [17:0]     sh_q, sh_d;
    logic            par_q, par_d;
    logic [1:0]      cmd_q, cmd_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            id_miss_q, id_miss_d;
    logic            rf_s, tick, par_ok;

    assign rf_s   = sync2_q;
    assign tick   = (cnt_q == '0);
    assign par_ok = ~^{sh_q, par_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            par_q       <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            id_miss_q   <= 1'b0;
        end else begin
            sync1_q     <= rf_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            par_q       <= par_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            id_miss_q   <= id_miss_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        par_d       = par_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        id_miss_d   = 1'b0;

        // Every sampling state counts down to zero and reloads a full bit period.
        if (state_q != S_IDLE && state_q != S_WAIT_IDLE) begin
            cnt_d = tick ? FULL_M1 : cnt_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!rf_s && prev_q) begin
                    cnt_d   = HALF_M1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rf_s) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    sh_d = {rf_s, sh_q[17:1]};
                    if (idx_q == 5'd17) begin
                        state_d = S_PARITY;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    par_d   = rf_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (!rf_s || !par_ok) begin
                        frame_err_d = 1'b1;
                        state_d     = rf_s ? S_IDLE : S_WAIT_IDLE;
                    end else if (sh_q[15:0] != DEVICE_ID) begin
                        id_miss_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        cmd_d       = sh_q[17:16];
                        cmd_valid_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rf_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;
    assign id_miss   = id_miss_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_keyfob_decoder.sv
// Scoreboard bench for keyfob_decoder with BIT_TICKS = 8: the driver queues the
// expected strobe per frame, a negedge monitor pops and checks kind, cycle and cmd.
module tb_keyfob_decoder;

    localparam int BT = 8;
    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_ERR   = 3'b010;
    localparam logic [2:0] K_MISS  = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [1:0] cmd;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rf_in = 1'b1;
    logic [1:0] cmd;
    logic       cmd_valid, frame_err, id_miss, busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    keyfob_decoder #(.BIT_TICKS(BT), .DEVICE_ID(16'hA5C3)) dut (
        .clk       (clk),
        .rst       (rst),
        .rf_in     (rf_in),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err),
        .id_miss   (id_miss),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard exactly.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (cmd_valid || frame_err || id_miss) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", int'({cmd_valid, frame_err, id_miss}), 0);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_kind", int'({cmd_valid, frame_err, id_miss}), int'(e.kind));
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("strobe_cmd", int'(cmd), int'(e.cmd));
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                chk("missing_strobe", cyc, e.cyc);
            end
        end
    end

    // Caller is aligned 1 ns after a rising edge; each bit lasts BT cycles.
    task automatic drive_bit(input logic b);
        rf_in = b;
        repeat (BT) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [15:0] id, input logic [1:0] c,
                              input logic flip_p, input logic stop,
                              input logic [2:0] kind, input logic [1:0] exp_cmd);
        logic [17:0] payload;
        logic        p;
        exp_t        e;
        payload = {c, id};
        p       = (^payload) ^ flip_p;
        e.kind  = kind;
        e.cmd   = exp_cmd;
        // Edge seen two cycles after rf_in falls; strobe lands at E + 165.
        e.cyc   = cyc + 2 + 165;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 18; i++) drive_bit(payload[i]);
        drive_bit(p);
        drive_bit(stop);
    endtask

    initial begin
        int n0;
        logic [17:0] pl;

        #2;
        chk("reset_cmd", int'(cmd), 0);
        chk("reset_strobes", int'({cmd_valid, frame_err, id_miss}), 0);
        chk("reset_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        idle_bits(2);

        // Valid frame, then bad parity, then foreign ID: cmd must stay 1.
        send_frame(16'hA5C3, 2'd1, 1'b0, 1'b1, K_VALID, 2'd1);
        idle_bits(2);
        send_frame(16'hA5C3, 2'd1, 1'b1, 1'b1, K_ERR, 2'd1);
        idle_bits(2);
        send_frame(16'h1234, 2'd3, 1'b0, 1'b1, K_MISS, 2'd1);
        idle_bits(2);

        // Stop bit low, line held low: one frame_err, no retrigger.
        send_frame(16'hA5C3, 2'd0, 1'b0, 1'b0, K_ERR, 2'd1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (i % 10 == 5) chk("wait_idle_busy", int'(busy), 1);
        end
        rf_in = 1'b1;
        idle_bits(2);
        send_frame(16'hA5C3, 2'd2, 1'b0, 1'b1, K_VALID, 2'd2);
        idle_bits(2);

        // 3-cycle glitch: busy during E+1..E+4 only, where E = n0 + 2.
        n0 = cyc;
        rf_in = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rf_in = 1'b1;
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            chk("glitch_cycle", cyc, n0 + k);
            chk("glitch_busy", int'(busy), (k <= 6) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        idle_bits(2);

        // Reset in the middle of data bit 10 aborts asynchronously.
        pl = {2'd2, 16'hA5C3};
        drive_bit(1'b0);
        for (int i = 0; i < 10; i++) drive_bit(pl[i]);
        rf_in = pl[10];
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_cmd", int'(cmd), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_cmd", int'(cmd), 0);
        chk("midreset_strobes", int'({cmd_valid, frame_err, id_miss}), 0);
        chk("midreset_busy", int'(busy), 0);
        rf_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        idle_bits(3);
        send_frame(16'hA5C3, 2'd3, 1'b0, 1'b1, K_VALID, 2'd3);

        // Back-to-back frames separated only by the single stop bit.
        send_frame(16'hA5C3, 2'd0, 1'b0, 1'b1, K_VALID, 2'd0);
        send_frame(16'hA5C3, 2'd1, 1'b0, 1'b1, K_VALID, 2'd1);
        idle_bits(4);

        chk("scoreboard_drained", sb.size(), 0);
        chk("final_cmd", int'(cmd), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
